// File: rtl/calc_key_player.sv
// Plays calculator tokens as timed active-low key presses: repeated presses on the
// number or operator key, then an enter commit press (an evaluate token is a single enter press).
module calc_key_player #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic [1:0] tok_type,
  input  logic [7:0] tok_value,
  output logic       num_key_n,
  output logic       cal_key_n,
  output logic       enter_key_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // state  | meaning
  // IDLE   | waiting for a token, tok_ready high
  // PRESS  | number/operator key held low
  // GAP    | all keys high after a number/operator press
  // CPRESS | enter key held low (commit, or the evaluate press)
  // CGAP   | all keys high after the enter press; done on exit
  typedef enum logic [2:0] {IDLE, PRESS, GAP, CPRESS, CGAP} state_t;

  localparam logic [23:0] PRESS_LOAD = 24'(PRESS_CYCLES - 1);
  localparam logic [23:0] GAP_LOAD   = 24'(GAP_CYCLES - 1);

  state_t      state;
  logic [23:0] timer;
  logic [7:0]  presses_left;
  logic        use_cal;

  assign tok_ready = (state == IDLE) && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      presses_left <= '0;
      use_cal      <= 1'b0;
      num_key_n    <= 1'b1;
      cal_key_n    <= 1'b1;
      enter_key_n  <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tok_valid) begin
            case (tok_type)
              2'd0: begin
                if (tok_value != 8'd0) begin
                  state        <= PRESS;
                  timer        <= PRESS_LOAD;
                  presses_left <= tok_value - 8'd1;
                  use_cal      <= 1'b0;
                  num_key_n    <= 1'b0;
                  busy         <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              2'd1: begin
                if (tok_value >= 8'd2 && tok_value <= 8'd5) begin
                  state        <= PRESS;
                  timer        <= PRESS_LOAD;
                  presses_left <= tok_value - 8'd1;
                  use_cal      <= 1'b1;
                  cal_key_n    <= 1'b0;
                  busy         <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              2'd2: begin
                state       <= CPRESS;
                timer       <= PRESS_LOAD;
                enter_key_n <= 1'b0;
                busy        <= 1'b1;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        PRESS: begin
          if (timer == 24'd0) begin
            state     <= GAP;
            timer     <= GAP_LOAD;
            num_key_n <= 1'b1;
            cal_key_n <= 1'b1;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        GAP: begin
          if (timer == 24'd0) begin
            timer <= PRESS_LOAD;
            if (presses_left != 8'd0) begin
              state        <= PRESS;
              presses_left <= presses_left - 8'd1;
              num_key_n    <= use_cal;
              cal_key_n    <= !use_cal;
            end else begin
              state       <= CPRESS;
              enter_key_n <= 1'b0;
            end
          end else begin
            timer <= timer - 24'd1;
          end
        end
        CPRESS: begin
          if (timer == 24'd0) begin
            state       <= CGAP;
            timer       <= GAP_LOAD;
            enter_key_n <= 1'b1;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        CGAP: begin
          if (timer == 24'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_key_player.sv
// Directed and randomized token playback checked against a per-cycle model that
// derives key levels from press index and phase arithmetic.
module tb_calc_key_player;
  localparam int P = 2;
  localparam int G = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tok_valid = 1'b0;
  logic [1:0] tok_type = '0;
  logic [7:0] tok_value = '0;
  logic       tok_ready, num_key_n, cal_key_n, enter_key_n, busy, done, err;

  int checks = 0;
  int errors = 0;

  calc_key_player #(.PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_type(tok_type), .tok_value(tok_value), .num_key_n(num_key_n),
    .cal_key_n(cal_key_n), .enter_key_n(enter_key_n), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // observed bundle: {num, cal, enter, busy, done, err, tok_ready}
  function automatic logic [6:0] outs();
    return {num_key_n, cal_key_n, enter_key_n, busy, done, err, tok_ready};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a token in the current cycle and check every following cycle.
  // stop_at > 0 returns while still in that cycle of the sequence.
  task automatic play(input logic [1:0] t, input logic [7:0] v, input int stop_at);
    int nmain, key, total, idx, ph;
    bit valid, low;
    logic [6:0] exp;
    valid = 1'b1;
    nmain = 0;
    key   = 2;
    if (t == 2'd0 && v != 8'd0) begin nmain = v; key = 0; end
    else if (t == 2'd1 && v >= 8'd2 && v <= 8'd5) begin nmain = v; key = 1; end
    else if (t != 2'd2) valid = 1'b0;
    total = (nmain + 1) * (P + G);
    chk("ready_before_accept", outs() & 7'b0000001, 7'b0000001);
    tok_valid = 1'b1;
    tok_type  = t;
    tok_value = v;
    step();
    tok_valid = 1'b0;
    if (!valid) begin
      chk($sformatf("err_pulse t%0d v%0d", t, v), outs(), 7'b1110011);
      step();
      chk($sformatf("err_after t%0d v%0d", t, v), outs(), 7'b1110001);
      return;
    end
    for (int k = 1; k <= total; k++) begin
      tok_type  = 2'($urandom);
      tok_value = 8'($urandom);
      idx = (k - 1) / (P + G);
      ph  = (k - 1) % (P + G);
      low = (ph < P);
      if (idx >= nmain) key = 2;
      exp = {!(low && key == 0), !(low && key == 1), !(low && key == 2), 1'b1, 3'b000};
      chk($sformatf("t%0d v%0d cycle %0d", t, v, k), outs(), exp);
      if (k == stop_at) return;
      step();
    end
    chk($sformatf("done_cycle t%0d v%0d", t, v), outs(), 7'b1110101);
  endtask

  initial begin
    logic [1:0] rt;
    logic [7:0] rv;
    step();
    step();
    chk("in_reset", outs(), 7'b1110000);
    reset = 1'b1;
    step();
    chk("after_reset", outs(), 7'b1110001);

    play(2'd0, 8'd3, 0);
    step();
    chk("idle_gap", outs(), 7'b1110001);
    play(2'd1, 8'd4, 0);
    play(2'd2, 8'd0, 0);
    step();
    play(2'd0, 8'd0, 0);
    play(2'd1, 8'd7, 0);
    play(2'd3, 8'd1, 0);
    play(2'd1, 8'd1, 0);

    play(2'd0, 8'd5, 6);
    reset     = 1'b0;
    tok_valid = 1'b1;
    tok_type  = 2'd0;
    tok_value = 8'd9;
    step();
    chk("mid_reset_release", outs(), 7'b1110000);
    step();
    chk("valid_ignored_in_reset", outs(), 7'b1110000);
    reset     = 1'b1;
    tok_valid = 1'b0;
    step();
    chk("idle_after_mid_reset", outs(), 7'b1110001);
    play(2'd0, 8'd2, 0);

    for (int i = 0; i < 12; i++) begin
      rt = 2'($urandom_range(0, 3));
      case (rt)
        2'd0:    rv = 8'($urandom_range(0, 12));
        2'd1:    rv = 8'($urandom_range(0, 7));
        default: rv = 8'($urandom);
      endcase
      play(rt, rv, 0);
      if ($urandom_range(0, 1) == 1) step();
    end

    play(2'd0, 8'd255, 0);
    step();
    chk("final_idle", outs(), 7'b1110001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
